// File: rtl/can_bit_stuffing_pkg.sv
// can_pkg: shared constants and types for the CAN bit-stuffing engine
package can_pkg;
    localparam int CAN_STUFF_LEN = 5;
    localparam int CAN_DATA_W    = 64;
    typedef logic [2:0] run_cnt_t;
endpackage

// File: rtl/can_bit_stuffing_if.sv
// can_bit_stuffing_if: parallel word in, stuffed word and status out
//   data_in   : unstuffed bits, MSB transmitted first
//   data_out  : stuffed stream, MSB is the first stuffed bit once done
//   done      : DATA_W output bits produced for the current data_in
//   stuff_cnt : number of stuff bits inserted into data_out
//   ovf       : input bits truncated by stuffing (CAN_BIT_STUFFING_OVF_EN only)
interface can_bit_stuffing_if #(parameter int DATA_W = 64);
    localparam int CW = $clog2(DATA_W) + 1;
    logic [DATA_W-1:0] data_in;
    logic [DATA_W-1:0] data_out;
    logic              done;
    logic [CW-1:0]     stuff_cnt;
`ifdef CAN_BIT_STUFFING_OVF_EN
    logic              ovf;
    modport master (output data_in, input data_out, done, stuff_cnt, ovf);
    modport slave  (input data_in, output data_out, done, stuff_cnt, ovf);
`else
    modport master (output data_in, input data_out, done, stuff_cnt);
    modport slave  (input data_in, output data_out, done, stuff_cnt);
`endif
endinterface

// File: rtl/can_stuff_run_ctr.sv
// can_stuff_run_ctr: tracks the current run of equal output bits and flags when a stuff bit is due
//   clk, rst    : clock, async active-high reset
//   restart_i   : first bit of a new word is emitted this edge
//   adv_i       : a following bit is emitted this edge
//   bit_i       : the bit being emitted
//   run_val_o   : value of the current run
//   stuff_now_o : run has reached STUFF_LEN, next emitted bit must be a stuff bit
module can_stuff_run_ctr
    import can_pkg::*;
#(
    parameter int STUFF_LEN = CAN_STUFF_LEN
) (
    input  logic clk,
    input  logic rst,
    input  logic restart_i,
    input  logic adv_i,
    input  logic bit_i,
    output logic run_val_o,
    output logic stuff_now_o
);
    logic     run_val_q, run_val_d;
    run_cnt_t run_cnt_q, run_cnt_d;

    // A stuff bit is always ~run_val, so it naturally starts a fresh run of one.
    always_comb begin
        run_val_d = (restart_i | adv_i) ? bit_i : run_val_q;
        run_cnt_d = !(restart_i | adv_i)             ? run_cnt_q :
                    (restart_i | (bit_i != run_val_q)) ? run_cnt_t'(1) : run_cnt_q + run_cnt_t'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            run_val_q <= 1'b0;
            run_cnt_q <= '0;
        end else begin
            run_val_q <= run_val_d;
            run_cnt_q <= run_cnt_d;
        end
    end

    assign run_val_o   = run_val_q;
    assign stuff_now_o = run_cnt_q == run_cnt_t'(STUFF_LEN);
endmodule

// File: rtl/can_bit_stuffing.sv
// can_bit_stuffing: serial CAN bit-stuffing engine building the stuffed stream in a parallel register
//   clk, rst : clock, async active-high reset
//   bus      : can_bit_stuffing_if.slave (data_in in; data_out, done, stuff_cnt out)
//   Optional macro CAN_BIT_STUFFING_OVF_EN adds bus.ovf (input bits truncated by stuffing).
module can_bit_stuffing
    import can_pkg::*;
#(
    parameter int DATA_W    = CAN_DATA_W,
    parameter int STUFF_LEN = CAN_STUFF_LEN
) (
    input logic               clk,
    input logic               rst,
    can_bit_stuffing_if.slave bus
);
    localparam int IW = $clog2(DATA_W);
    localparam int CW = IW + 1;

    logic [DATA_W-1:0] shadow_q, shadow_d, data_out_q, data_out_d;
    logic              start_pending_q, start_pending_d, done_q, done_d;
    logic [CW-1:0]     idx_q, idx_d, ocnt_q, ocnt_d, stuff_cnt_q, stuff_cnt_d;
    logic              restart, busy, exhausted, stuff, run_val, stuff_now, emit_bit;
`ifdef CAN_BIT_STUFFING_OVF_EN
    logic              ovf_q, ovf_d;
`endif

    assign restart   = start_pending_q | (bus.data_in != shadow_q);
    assign busy      = ocnt_q < CW'(DATA_W);
    // Once the input is used up only run-rule stuff bits can be emitted.
    assign exhausted = idx_q >= CW'(DATA_W);
    assign stuff     = stuff_now | exhausted;
    assign emit_bit  = restart ? bus.data_in[DATA_W-1] :
                       stuff   ? ~run_val : shadow_q[IW'(CW'(DATA_W - 1) - idx_q)];

    can_stuff_run_ctr #(.STUFF_LEN(STUFF_LEN)) u_run (
        .clk         (clk),
        .rst         (rst),
        .restart_i   (restart),
        .adv_i       (~restart & busy),
        .bit_i       (emit_bit),
        .run_val_o   (run_val),
        .stuff_now_o (stuff_now)
    );

    always_comb begin
        shadow_d        = shadow_q;
        start_pending_d = start_pending_q;
        data_out_d      = data_out_q;
        done_d          = done_q;
        idx_d           = idx_q;
        ocnt_d          = ocnt_q;
        stuff_cnt_d     = stuff_cnt_q;
`ifdef CAN_BIT_STUFFING_OVF_EN
        ovf_d           = ovf_q;
`endif
        if (restart) begin
            shadow_d        = bus.data_in;
            start_pending_d = 1'b0;
            data_out_d      = {{(DATA_W-1){1'b0}}, emit_bit};
            done_d          = 1'b0;
            idx_d           = CW'(1);
            ocnt_d          = CW'(1);
            stuff_cnt_d     = '0;
`ifdef CAN_BIT_STUFFING_OVF_EN
            ovf_d           = 1'b0;
`endif
        end else if (busy) begin
            data_out_d      = {data_out_q[DATA_W-2:0], emit_bit};
            idx_d           = stuff ? idx_q : idx_q + CW'(1);
            ocnt_d          = ocnt_q + CW'(1);
            stuff_cnt_d     = stuff_cnt_q + CW'(stuff);
            done_d          = ocnt_d == CW'(DATA_W);
`ifdef CAN_BIT_STUFFING_OVF_EN
            ovf_d           = done_d & (idx_d < CW'(DATA_W));
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow_q        <= '0;
            start_pending_q <= 1'b1;
            data_out_q      <= '0;
            done_q          <= 1'b0;
            idx_q           <= '0;
            ocnt_q          <= '0;
            stuff_cnt_q     <= '0;
`ifdef CAN_BIT_STUFFING_OVF_EN
            ovf_q           <= 1'b0;
`endif
        end else begin
            shadow_q        <= shadow_d;
            start_pending_q <= start_pending_d;
            data_out_q      <= data_out_d;
            done_q          <= done_d;
            idx_q           <= idx_d;
            ocnt_q          <= ocnt_d;
            stuff_cnt_q     <= stuff_cnt_d;
`ifdef CAN_BIT_STUFFING_OVF_EN
            ovf_q           <= ovf_d;
`endif
        end
    end

    assign bus.data_out  = data_out_q;
    assign bus.done      = done_q;
    assign bus.stuff_cnt = stuff_cnt_q;
`ifdef CAN_BIT_STUFFING_OVF_EN
    assign bus.ovf       = ovf_q;
`endif
endmodule

// File: tb/tb_can_bit_stuffing.sv
// tb_can_bit_stuffing: directed table-driven bench for can_bit_stuffing
module tb_can_bit_stuffing;
    import can_pkg::*;
    localparam int W = CAN_DATA_W;

    typedef struct {
        logic [W-1:0] din;
        logic [W-1:0] dout;
        int           cnt;
        logic         ovf;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;
    vec_t vecs[6];
    vec_t zero_v;

    can_bit_stuffing_if #(.DATA_W(W)) bus();

    can_bit_stuffing #(.DATA_W(W), .STUFF_LEN(CAN_STUFF_LEN)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Called at the negedge where data_in has just been given a new value (or
    // where the restart is otherwise due at the next posedge).
    task automatic wait_check(input string name, input vec_t v);
        int n;
        logic [W-1:0] held;
        @(negedge clk);
        check({name, "_first"}, bus.data_out, W'(v.din[W-1]));
        check({name, "_done_lo"}, W'(bus.done), W'(0));
        n = 1;
        while (!bus.done && n < 100) begin
            @(negedge clk);
            n++;
        end
        check({name, "_latency"}, W'(n), W'(W));
        check({name, "_dout"}, bus.data_out, v.dout);
        check({name, "_cnt"}, W'(bus.stuff_cnt), W'(v.cnt));
`ifdef CAN_BIT_STUFFING_OVF_EN
        check({name, "_ovf"}, W'(bus.ovf), W'(v.ovf));
`endif
        held = bus.data_out;
        @(negedge clk);
        check({name, "_hold_done"}, W'(bus.done), W'(1));
        check({name, "_hold_dout"}, bus.data_out, held);
    endtask

    initial begin
        vecs[0] = '{64'hAAAA_AAAA_AAAA_AAAA, 64'hAAAA_AAAA_AAAA_AAAA, 0,  1'b0};
        vecs[1] = '{64'h0000_0000_0000_0000, 64'h0410_4104_1041_0410, 10, 1'b1};
        vecs[2] = '{64'h0000_0000_FF00_FF00, 64'h0410_4104_13EE_08FB, 9,  1'b1};
        vecs[3] = '{64'h0000_0000_0000_80FF, 64'h0410_4104_1041_0441, 10, 1'b1};
        vecs[4] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFBEF_BEFB_EFBE_FBEF, 10, 1'b1};
        vecs[5] = '{64'h5555_5555_5555_5555, 64'h5555_5555_5555_5555, 0,  1'b0};
        zero_v  = vecs[1];

        bus.data_in = '0;
        #12;
        check("reset_dout", bus.data_out, '0);
        check("reset_done", W'(bus.done), W'(0));
        check("reset_cnt", W'(bus.stuff_cnt), W'(0));
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            bus.data_in = vecs[i].din;
            wait_check($sformatf("vec%0d", i), vecs[i]);
        end

        // Abort mid-run: 80FF run is replaced by FF00FF00 after 20 edges.
        @(negedge clk);
        bus.data_in = vecs[3].din;
        repeat (20) @(negedge clk);
        check("abort_done_lo", W'(bus.done), W'(0));
        bus.data_in = vecs[2].din;
        wait_check("abort", vecs[2]);

        // Async reset mid-run, then restart from data_in==0 via start_pending.
        @(negedge clk);
        bus.data_in = vecs[0].din;
        repeat (10) @(negedge clk);
        #2;
        rst = 1'b1;
        bus.data_in = '0;
        #1;
        check("areset_dout", bus.data_out, '0);
        check("areset_done", W'(bus.done), W'(0));
        check("areset_cnt", W'(bus.stuff_cnt), W'(0));
        @(negedge clk);
        rst = 1'b0;
        wait_check("post_reset_zero", zero_v);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/can_bit_stuffing.md
Name: can_bit_stuffing

Overview:
- Serial CAN bit-stuffing engine. Scans a parallel input word MSB-first, one output bit per clock, and builds the stuffed bit stream in a parallel output register.
- Applies the CAN rule: after 5 consecutive equal bits on the output stream, insert one complementary bit.
- Sits between frame assembly (parallel frame bits) and the serializer/TX shifter.

Parameters:
- DATA_W, 64, width of data_in and data_out (stuffed stream is truncated to DATA_W bits).
- STUFF_LEN, 5, run length of equal bits that triggers insertion of a stuff bit.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- data_in  input  DATA_W  unstuffed bits; data_in[DATA_W-1] is transmitted first.
- data_out  output  DATA_W  stuffed stream; after done, data_out[DATA_W-1] is the first stuffed bit.
- done  output  1  high once DATA_W output bits have been produced for the current data_in.
- stuff_cnt  output  $clog2(DATA_W)+1  number of stuff bits inserted into data_out.

Behaviour:
- Reset (async, rst=1): data_out=0, done=0, stuff_cnt=0, input index=0, run count=0, shadow=0, start_pending=1.
- Restart condition, evaluated on each rising edge: (start_pending==1) or (data_in != shadow).
- On restart:
  - Capture data_in into shadow and clear start_pending.
  - Emit data_in[DATA_W-1] at that same edge: data_out <= {DATA_W-1 zeros, bit}.
  - Set run value=bit, run count=1, input index=1, out count=1, stuff_cnt=0, done=0.
- Otherwise, while out count < DATA_W, one bit is emitted per edge, with data_out shifting left and the new bit entering at bit 0:
  - If run count==STUFF_LEN: emit ~run value (stuff bit), set run value=~run value, run count=1, stuff_cnt+1. The input index does not advance.
  - Else: emit shadow[DATA_W-1-index]. If it equals run value, run count+1; else run value=bit and run count=1. Index+1.
- A stuff bit starts a new run of length 1, so it can participate in the next 5-bit run.
- When out count reaches DATA_W, done=1 and data_out, stuff_cnt and done hold until the next restart. Remaining unconsumed input bits are dropped.
- Latency: done asserts exactly DATA_W edges after the restart edge, inclusive of that edge.
- data_out shows partially filled content before done, and holds it when done.
- A data_in change mid-operation aborts the run and restarts immediately; no bits are carried over.
- If the input index reaches DATA_W before out count does (impossible with STUFF_LEN>=1 and equal widths), the block pads with run-rule stuff bits only.
- Stuff bits are never inserted after the final output bit.

Optional Feature:
- Macro: CAN_BIT_STUFFING_OVF_EN.
- When defined: adds output ovf (1 bit), reset 0. Set together with done when the input index is < DATA_W, i.e. input bits were truncated because stuffing lengthened the stream. Cleared on restart.
- When undefined: no ovf port and no related logic.

Decomposition:
- Package can_pkg holds:
  - localparam CAN_STUFF_LEN=5 (default for STUFF_LEN).
  - CAN_DATA_W=64.
  - typedef for the run counter (3 bits).
- Optional sub-module can_stuff_run_ctr: tracks run value/count and outputs the stuff-now flag. The top level owns the shift register, index and counters.

Test Plan:
- data_in=64'hAAAA_AAAA_AAAA_AAAA, wait 64 cycles -> data_out=64'hAAAA_AAAA_AAAA_AAAA, stuff_cnt=0, done=1.
- data_in=0 after reset -> data_out = "000001" repeated 10 times followed by "0000", stuff_cnt=10, done at cycle 64.
- data_in=32'hFF00FF00 (upper 32 bits zero) -> data_out = "000001"x6, "00", "111110111", "000001000", "11111011"; stuff_cnt=9. With OVF_EN: ovf=1.
- data_in=16'h80FF (upper 48 bits zero) -> data_out = "000001"x9, "000", "1", "00000", "1"; stuff_cnt=10.
- Change data_in at cycle 20 of a run -> restart at that edge, with done low for 64 further edges; the result equals the clean-run result for the new value.
- Assert rst mid-run -> all outputs 0 asynchronously; after release, the first edge restarts even if data_in==0.
